// File: rtl/rca_config_sequencer.sv
// rca_config_sequencer: takes decoded RCA instructions from issue, streams
// configuration words to the accelerator grid, tracks which slots are fully
// configured, and launches one USE operation at a time on a configured slot.
module rca_config_sequencer #(
    parameter int NUM_RCAS         = 2,
    parameter int CPU_REG_WORDS    = 1,
    parameter int GRID_MUX_WORDS   = 4,
    parameter int IO_MUX_WORDS     = 2,
    parameter int RESULT_MUX_WORDS = 1,
    localparam int ID_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          issue_fn3,
    input  logic [ID_W-1:0]     issue_rca_id,
    input  logic [31:0]         issue_rs1,
    input  logic [31:0]         issue_rs2,

    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [ID_W-1:0]     cfg_rca,
    output logic [1:0]          cfg_type,
    output logic [7:0]          cfg_index,
    output logic [31:0]         cfg_data,

    output logic                use_valid,
    input  logic                use_ready,
    output logic [ID_W-1:0]     use_rca,
    input  logic                use_done,

    output logic [NUM_RCAS-1:0] cfg_complete,
    output logic                err,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CFG       = 2'd1,
        USE_ISSUE = 2'd2,
        USE_RUN   = 2'd3
    } state_t;

    state_t state, state_next;

    // One flag per (slot, config type); a slot is complete once all four are set.
    logic [NUM_RCAS-1:0][3:0] written;

    // Instruction decode, evaluated every cycle against the presented instruction.
    logic        accept;
    logic        is_use;
    logic        is_cfg;
    logic [2:0]  fn_minus1;
    logic [1:0]  type_dec;
    logic [31:0] type_words;
    logic [31:0] rca_wide;
    logic        rca_ok;
    logic        instr_ok;

    assign accept    = issue_valid && (state == IDLE);
    assign is_use    = (issue_fn3 == 3'd0);
    assign is_cfg    = (issue_fn3 >= 3'd1) && (issue_fn3 <= 3'd4);
    assign fn_minus1 = issue_fn3 - 3'd1;
    assign type_dec  = fn_minus1[1:0];
    // Widened so the range check stays meaningful when NUM_RCAS is not a power of two.
    assign rca_wide  = 32'(issue_rca_id);
    assign rca_ok    = (rca_wide < 32'(NUM_RCAS));

    // Number of legal word indices for the decoded configuration type.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        type_words = 32'd0;
        case (type_dec)
            2'd0:    type_words = 32'(CPU_REG_WORDS);
            2'd1:    type_words = 32'(GRID_MUX_WORDS);
            2'd2:    type_words = 32'(IO_MUX_WORDS);
            default: type_words = 32'(RESULT_MUX_WORDS);
        endcase
    end

    // The full 32-bit index is checked, so high garbage bits cannot alias a legal word.
    assign instr_ok = rca_ok &&
                      ((is_cfg && (issue_rs1 < type_words)) ||
                       (is_use && cfg_complete[issue_rca_id]));

    // Per-slot completeness is the AND of that slot's four type flags.
    generate
        for (genvar r = 0; r < NUM_RCAS; r++) begin : g_complete
            assign cfg_complete[r] = &written[r];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next  = state;
        issue_ready = 1'b0;
        cfg_valid   = 1'b0;
        use_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                busy        = 1'b0;
                if (accept && instr_ok) state_next = is_use ? USE_ISSUE : CFG;
            end
            CFG: begin
                cfg_valid = 1'b1;
                if (cfg_ready) state_next = IDLE;
            end
            USE_ISSUE: begin
                use_valid = 1'b1;
                if (use_ready) state_next = USE_RUN;
            end
            USE_RUN: begin
                if (use_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload capture on accept, registered error pulse, and written-flag tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the flag array is tiny and its reset value is architectural, so it is reset like any other register.
            written   <= '0;
            cfg_rca   <= '0;
            cfg_type  <= '0;
            cfg_index <= '0;
            cfg_data  <= '0;
            use_rca   <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && !instr_ok;
            if (accept && instr_ok && is_cfg) begin
                cfg_rca   <= issue_rca_id;
                cfg_type  <= type_dec;
                cfg_index <= issue_rs1[7:0];
                cfg_data  <= issue_rs2;
            end
            if (accept && instr_ok && is_use) begin
                use_rca <= issue_rca_id;
            end
            if ((state == CFG) && cfg_ready) begin
                written[cfg_rca][cfg_type] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Self-checking bench for rca_config_sequencer: a driver issues directed and
// random instructions while a reference model predicts each grid-side response
// into a queue; a negedge monitor pops and compares every response it sees.
module tb_rca_config_sequencer;

    localparam int NUM_RCAS = 2;
    localparam int ID_W     = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                issue_valid = 1'b0;
    logic                issue_ready;
    logic [2:0]          issue_fn3 = '0;
    logic [ID_W-1:0]     issue_rca_id = '0;
    logic [31:0]         issue_rs1 = '0;
    logic [31:0]         issue_rs2 = '0;
    logic                cfg_valid;
    logic                cfg_ready = 1'b0;
    logic [ID_W-1:0]     cfg_rca;
    logic [1:0]          cfg_type;
    logic [7:0]          cfg_index;
    logic [31:0]         cfg_data;
    logic                use_valid;
    logic                use_ready = 1'b0;
    logic [ID_W-1:0]     use_rca;
    logic                use_done = 1'b0;
    logic [NUM_RCAS-1:0] cfg_complete;
    logic                err;
    logic                busy;

    rca_config_sequencer #(.NUM_RCAS(NUM_RCAS)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fn3(issue_fn3),
        .issue_rca_id(issue_rca_id), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rca(cfg_rca), .cfg_type(cfg_type),
        .cfg_index(cfg_index), .cfg_data(cfg_data),
        .use_valid(use_valid), .use_ready(use_ready), .use_rca(use_rca), .use_done(use_done),
        .cfg_complete(cfg_complete), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int { EV_CFG, EV_USE, EV_ERR } ev_t;
    typedef struct {
        ev_t         kind;
        logic [0:0]  rca;
        logic [1:0]  typ;
        logic [7:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit   wr[NUM_RCAS][4];
    int   words[4] = '{1, 4, 2, 1};

    function automatic logic [1:0] model_cc();
        logic [1:0] cc;
        for (int r = 0; r < NUM_RCAS; r++) cc[r] = wr[r][0] & wr[r][1] & wr[r][2] & wr[r][3];
        return cc;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NUM_RCAS; r++)
            for (int t = 0; t < 4; t++) wr[r][t] = 1'b0;
    endfunction

    // ---------------- grid-side ready generation ----------------
    bit cfg_force = 1'b0, cfg_force_val = 1'b0;
    bit use_force = 1'b0, use_force_val = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cfg_ready = cfg_force ? cfg_force_val : 1'($urandom);
            use_ready = use_force ? use_force_val : 1'($urandom);
        end
    end

    // ---------------- monitor ----------------
    exp_t        mon_e;
    logic        prev_cfg_stall = 1'b0, prev_use_stall = 1'b0;
    logic [0:0]  prev_cfg_rca, prev_use_rca;
    logic [1:0]  prev_cfg_type;
    logic [7:0]  prev_cfg_index;
    logic [31:0] prev_cfg_data;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_valid && cfg_ready) begin
                if (exp_q.size() == 0) check("cfg_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("cfg_kind", 64'(mon_e.kind), 64'(EV_CFG));
                    check("cfg_rca", cfg_rca, mon_e.rca);
                    check("cfg_type", cfg_type, mon_e.typ);
                    check("cfg_index", cfg_index, mon_e.idx);
                    check("cfg_data", cfg_data, mon_e.data);
                end
            end
            if (use_valid && use_ready) begin
                if (exp_q.size() == 0) check("use_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("use_kind", 64'(mon_e.kind), 64'(EV_USE));
                    check("use_rca", use_rca, mon_e.rca);
                end
            end
            if (err) begin
                if (exp_q.size() == 0) check("err_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("err_kind", 64'(mon_e.kind), 64'(EV_ERR));
                end
            end
            if (prev_cfg_stall && cfg_valid) begin
                check("cfg_stable", {cfg_rca, cfg_type, cfg_index, cfg_data},
                      {prev_cfg_rca, prev_cfg_type, prev_cfg_index, prev_cfg_data});
            end
            if (prev_use_stall && use_valid) check("use_stable", use_rca, prev_use_rca);
        end
        prev_cfg_stall = rst_n && cfg_valid && !cfg_ready;
        prev_use_stall = rst_n && use_valid && !use_ready;
        prev_cfg_rca   = cfg_rca;
        prev_cfg_type  = cfg_type;
        prev_cfg_index = cfg_index;
        prev_cfg_data  = cfg_data;
        prev_use_rca   = use_rca;
    end

    // ---------------- driver helpers ----------------
    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!issue_ready && n < 200);
        check("idle_timeout", issue_ready, 1);
    endtask

    // Presents one instruction for one accepting edge and predicts the response.
    task automatic issue(input logic [2:0] fn3, input logic [0:0] id,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         output ev_t kind);
        exp_t e;
        e.kind = EV_ERR;
        e.rca  = id;
        e.typ  = 2'd0;
        e.idx  = rs1[7:0];
        e.data = rs2;
        if (fn3 == 3'd0) begin
            if (model_cc()[id]) e.kind = EV_USE;
        end else if (fn3 <= 3'd4) begin
            int t = int'(fn3) - 1;
            if (rs1 < 32'(words[t])) begin
                e.kind = EV_CFG;
                e.typ  = 2'(t);
                wr[id][t] = 1'b1;
            end
        end
        issue_valid  = 1'b1;
        issue_fn3    = fn3;
        issue_rca_id = id;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        exp_q.push_back(e);
        kind = e.kind;
    endtask

    // Plays the grid for a launched USE: waits for the launch, then pulses use_done.
    task automatic grid_run(input int delay);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(use_valid && use_ready) && n < 200);
        check("use_hs_timeout", use_valid && use_ready, 1);
        @(posedge clk);
        repeat (delay) @(posedge clk);
        #1 use_done = 1'b1;
        @(posedge clk);
        #1 use_done = 1'b0;
    endtask

    task automatic expect_err_now();
        @(negedge clk);
        check("err_pulse", err, 1);
        check("err_no_cfg", cfg_valid, 0);
        check("err_no_use", use_valid, 0);
        check("err_ready", issue_ready, 1);
        @(negedge clk);
        check("err_one_cycle", err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        ev_t k;
        int  cnt;

        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_use_valid", use_valid, 0);
        check("rst_err", err, 0);
        check("rst_complete", cfg_complete, 2'b00);

        // USE on an unconfigured slot is rejected.
        issue(3'd0, 1'b0, 32'd0, 32'd0, k);
        expect_err_now();
        check("use_reject_cc", cfg_complete, 2'b00);
        // A stray use_done while idle has no effect.
        #1 use_done = 1'b1;
        @(posedge clk);
        #1 use_done = 1'b0;
        @(negedge clk);
        check("stray_done_busy", busy, 0);

        // Full configuration of slot 1, one op every two cycles.
        cfg_force = 1'b1;
        cfg_force_val = 1'b1;
        wait_idle();
        cnt = 0;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < words[t]; i++) begin
                issue(3'(t + 1), 1'b1, 32'(i), 32'hA5A5_0000 + 32'(cnt), k);
                cnt++;
                @(negedge clk);
                check("cfg_valid_next", cfg_valid, 1);
                check("cfg_busy_ready", issue_ready, 0);
                @(negedge clk);
                check("cfg_done_ready", issue_ready, 1);
                check("cfg_cc_step", cfg_complete, model_cc());
            end
        end
        check("cfg_cc_final", cfg_complete, 2'b10);

        // Out-of-range indices, including high rs1 bits.
        issue(3'd2, 1'b1, 32'd4, 32'h1, k);
        expect_err_now();
        issue(3'd2, 1'b1, 32'h0000_0100, 32'h2, k);
        expect_err_now();
        issue(3'd1, 1'b0, 32'h8000_0000, 32'h3, k);
        expect_err_now();
        check("idx_reject_cc", cfg_complete, 2'b10);

        // Illegal function codes.
        issue(3'd7, 1'b0, 32'd0, 32'd0, k);
        expect_err_now();
        issue(3'd5, 1'b1, 32'd0, 32'd0, k);
        expect_err_now();

        // USE with launch back-pressure for three cycles.
        use_force = 1'b1;
        use_force_val = 1'b0;
        issue(3'd0, 1'b1, 32'd0, 32'd0, k);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!use_valid) break;
            cnt++;
            check("use_rca_held", use_rca, 1);
            if (cnt == 3) use_force_val = 1'b1;
        end
        check("use_valid_cycles", 32'(cnt), 32'd4);
        check("use_run_busy", busy, 1);
        repeat (4) @(posedge clk);
        #1 use_done = 1'b1;
        @(negedge clk);
        check("use_run_not_ready", issue_ready, 0);
        @(posedge clk);
        #1 use_done = 1'b0;
        @(negedge clk);
        check("use_done_ready", issue_ready, 1);

        // Random traffic with random grid back-pressure.
        cfg_force = 1'b0;
        use_force = 1'b0;
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  f;
            logic [31:0] idx;
            f   = 3'($urandom_range(0, 7));
            idx = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4));
            wait_idle();
            issue(f, 1'($urandom_range(0, 1)), idx, $urandom, k);
            if (k == EV_USE) grid_run($urandom_range(0, 4));
            wait_idle();
            check("rand_cc", cfg_complete, model_cc());
        end

        // Config stall, then reset in the middle of the handshake.
        cfg_force = 1'b1;
        cfg_force_val = 1'b0;
        wait_idle();
        @(negedge clk);
        issue(3'd2, 1'b0, 32'd1, 32'hDEAD_BEEF, k);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_cfg_valid", cfg_valid, 1);
            check("stall_not_ready", issue_ready, 0);
            check("stall_payload", {cfg_rca, cfg_type, cfg_index, cfg_data},
                  {1'b0, 2'd1, 8'd1, 32'hDEAD_BEEF});
        end
        rst_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        check("mid_rst_outputs",
              {cfg_valid, use_valid, err, busy, cfg_rca, cfg_type, cfg_index, cfg_data, use_rca},
              '0);
        check("mid_rst_cc", cfg_complete, 2'b00);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", issue_ready, 1);
        check("post_rst_cc", cfg_complete, 2'b00);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
